// File: rtl/estagio_busca.sv
// Instruction fetch stage: a single-outstanding-request fetch FSM feeding a
// 2-entry prefetch FIFO whose head is presented to control.
module estagio_busca (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        esc_cp,
  input  logic        desvio,
  input  logic [11:0] desvio_alvo,
  output logic [15:0] inst,
  output logic [11:0] pc,
  output logic        inst_valida
);

  typedef enum logic [1:0] {OCIOSO, PEDINDO, DESCARTE} estado_t;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] inst;
  } entrada_t;

  estado_t     estado, estado_nx;
  logic [11:0] pc_busca, pc_busca_nx;
  logic [11:0] alvo, alvo_nx;
  entrada_t    fila [2];
  logic [1:0]  cnt, cnt_nx;
  logic        pop, enq, wr_idx;

  // fila[0] is always the head; a pop shifts entry 1 down.
  assign inst_valida = (cnt != 2'd0);
  assign inst        = inst_valida ? fila[0].inst : 16'h0000;
  assign pc          = inst_valida ? fila[0].pc   : 12'h000;
  assign mem_addr    = pc_busca;

  // A redirect wins over both pop and enqueue.
  assign pop    = esc_cp & inst_valida & ~desvio;
  assign enq    = (estado == PEDINDO) & mem_ack & ~desvio;
  assign wr_idx = cnt[1] | (cnt[0] & ~pop);
  assign cnt_nx = desvio ? 2'd0 : cnt + 2'(enq) - 2'(pop);

  always_comb begin
    estado_nx   = estado;
    pc_busca_nx = pc_busca;
    alvo_nx     = alvo;
    mem_req     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (desvio) begin
          estado_nx   = PEDINDO;
          pc_busca_nx = desvio_alvo;
        end else if (cnt_nx != 2'd2) begin
          estado_nx = PEDINDO;
        end
      end
      PEDINDO: begin
        mem_req = 1'b1;
        if (desvio) begin
          if (mem_ack) begin
            pc_busca_nx = desvio_alvo;
          end else begin
            // pc_busca keeps the in-flight address so mem_addr stays stable
            estado_nx = DESCARTE;
            alvo_nx   = desvio_alvo;
          end
        end else if (mem_ack) begin
          pc_busca_nx = pc_busca + 12'd1;
          if (cnt_nx == 2'd2) estado_nx = OCIOSO;
        end
      end
      DESCARTE: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          estado_nx   = PEDINDO;
          pc_busca_nx = desvio ? desvio_alvo : alvo;
        end else if (desvio) begin
          alvo_nx = desvio_alvo;
        end
      end
      default: estado_nx = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= OCIOSO;
      pc_busca <= 12'h000;
      alvo     <= 12'h000;
    end else begin
      estado   <= estado_nx;
      pc_busca <= pc_busca_nx;
      alvo     <= alvo_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 2'd0;
      fila[0] <= '0;
      fila[1] <= '0;
    end else begin
      cnt <= cnt_nx;
      if (pop) fila[0] <= fila[1];
      // on pop+enqueue into slot 0 this later write wins
      if (enq) fila[wr_idx] <= '{pc: pc_busca, inst: mem_rdata};
    end
  end

endmodule

// File: tb/tb_estagio_busca.sv
// Bench for estagio_busca: directed scenarios plus random traffic, with a
// program-order scoreboard of consumed instructions and a latency-variable memory.
module tb_estagio_busca;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        esc_cp;
  logic        desvio;
  logic [11:0] desvio_alvo;
  logic [15:0] inst;
  logic [11:0] pc;
  logic        inst_valida;

  estagio_busca dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .esc_cp(esc_cp), .desvio(desvio), .desvio_alvo(desvio_alvo),
    .inst(inst), .pc(pc), .inst_valida(inst_valida)
  );

  always #5 clk = ~clk;

  int          nchk = 0, npass = 0, npop = 0;
  int          lat, lat_cfg;
  bit          rnd_lat;
  logic [11:0] req_addr, exp_pc;
  bit          flushed;

  // Memory image: distinct word per address, 16'h1234 at address 0.
  function automatic logic [15:0] memf(input logic [11:0] a);
    return 16'h1234 + {a, 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: scoreboard the consume about to happen, advance, then run the memory.
  task automatic tick();
    if (!rst_n) exp_pc = 12'h000;
    else if (desvio) exp_pc = desvio_alvo;
    else if (esc_cp && inst_valida) begin
      chk("pop_pc", pc, exp_pc);
      chk("pop_inst", inst, memf(exp_pc));
      exp_pc++;
      npop++;
    end
    flushed = rst_n && desvio;
    @(posedge clk); #1;
    if (flushed) chk("flush", inst_valida, 0);
    if (!inst_valida) chk("idle_out", {inst, pc}, 0);
    if (!rst_n) lat = -1;
    else begin
      if (mem_ack) begin mem_ack = 1'b0; lat = -1; end
      if (mem_req) begin
        if (lat < 0) begin
          lat = rnd_lat ? int'($urandom_range(1, 3)) : lat_cfg;
          req_addr = mem_addr;
        end else begin
          chk("addr_stable", mem_addr, req_addr);
          lat--;
          if (lat == 0) begin mem_ack = 1'b1; mem_rdata = memf(req_addr); end
        end
      end else lat = -1;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    tick();
    while (!inst_valida && n < 50) begin tick(); n++; end
    chk(tag, inst_valida, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; desvio = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_valid"}, inst_valida, 0);
  endtask

  initial begin
    int n;
    bit found;
    logic [11:0] q[$];

    rst_n = 1'b0; esc_cp = 1'b0; desvio = 1'b0; desvio_alvo = '0;
    mem_ack = 1'b0; mem_rdata = '0; lat = -1; lat_cfg = 1; rnd_lat = 1'b0; exp_pc = '0;
    tick(); tick();
    chk_reset_outs("rst");

    // Reset release, 1-cycle memory, always consuming
    esc_cp = 1'b1; rst_n = 1'b1;
    tick(); chk("c0_req", mem_req, 1); chk("c0_addr", mem_addr, 0);
    tick(); chk("c1_valid", inst_valida, 0);
    tick(); chk("c2_inst", inst, 16'h1234); chk("c2_pc", pc, 0); chk("c2_valid", inst_valida, 1);
    wait_valid("c_next_wait"); chk("c_next_pc", pc, 1);

    // Stall fills the FIFO, request stops, then drain
    esc_cp = 1'b0; do_reset();
    repeat (6) tick();
    chk("full_req", mem_req, 0); chk("full_inst", inst, memf(0)); chk("full_pc", pc, 0);
    esc_cp = 1'b1;
    tick(); chk("drain_pc1", pc, 1); chk("drain_valid1", inst_valida, 1);
    wait_valid("drain_wait2"); chk("drain_pc2", pc, 2);

    // Redirect while a 3-cycle request to 12'h005 is outstanding
    lat_cfg = 3; esc_cp = 1'b1; do_reset();
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      tick(); n++;
      found = mem_req && mem_addr == 12'h005 && lat == 3;
    end
    chk("reach_005", found, 1);
    desvio = 1'b1; desvio_alvo = 12'h0A0;
    tick(); desvio = 1'b0;
    chk("dsc_valid", inst_valida, 0); chk("dsc_req", mem_req, 1); chk("dsc_addr", mem_addr, 12'h005);
    repeat (3) tick();
    chk("redir_addr", mem_addr, 12'h0A0); chk("redir_valid", inst_valida, 0);
    wait_valid("redir_wait"); chk("redir_pc", pc, 12'h0A0); chk("redir_inst", inst, memf(12'h0A0));

    // Redirect coinciding with ack and pop
    lat_cfg = 1; esc_cp = 1'b0; do_reset();
    n = 0;
    while (!(mem_ack && inst_valida) && n < 50) begin tick(); n++; end
    chk("ackpop_setup", mem_ack && inst_valida, 1);
    esc_cp = 1'b1; desvio = 1'b1; desvio_alvo = 12'h3C0;
    tick(); desvio = 1'b0;
    chk("ackpop_valid", inst_valida, 0); chk("ackpop_req", mem_req, 1); chk("ackpop_addr", mem_addr, 12'h3C0);
    wait_valid("ackpop_wait"); chk("ackpop_pc", pc, 12'h3C0);

    // PC wrap at the top of the address space
    desvio = 1'b1; desvio_alvo = 12'hFFE;
    tick(); desvio = 1'b0;
    n = 0;
    while (q.size() < 3 && n < 60) begin
      if (inst_valida) q.push_back(pc);
      tick(); n++;
    end
    chk("wrap_cnt", q.size(), 3);
    if (q.size() == 3) begin
      chk("wrap_0", q[0], 12'hFFE); chk("wrap_1", q[1], 12'hFFF); chk("wrap_2", q[2], 12'h000);
    end

    // Reset mid-request with a stale ack during reset
    lat_cfg = 3;
    n = 0;
    while (!(mem_req && lat == 2) && n < 50) begin tick(); n++; end
    chk("midreq_setup", mem_req && lat == 2, 1);
    rst_n = 1'b0; #1;
    chk_reset_outs("arst");
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick(); chk_reset_outs("stale");
    mem_ack = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); chk("restart_req", mem_req, 1); chk("restart_addr", mem_addr, 0);
    wait_valid("restart_wait"); chk("restart_pc", pc, 0); chk("restart_inst", inst, memf(0));

    // Random traffic against the scoreboard
    rnd_lat = 1'b1; npop = 0;
    repeat (1500) begin
      esc_cp = ($urandom_range(0, 9) < 7);
      desvio = ($urandom_range(0, 39) == 0);
      desvio_alvo = 12'($urandom);
      tick();
    end
    desvio = 1'b0; esc_cp = 1'b1;
    repeat (10) tick();
    chk("liveness", npop > 100, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
